// File: rtl/unit_a_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : unit_a_sequencer
// Purpose  : Valid/ready front end for the 32-bit A-unit adder. Computes
//            S/c_out/O for sum, sub, ainv and inc, keeps a chaining
//            accumulator, and retires results through a 2-entry FIFO whose
//            head is presented on registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module unit_a_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [1:0]  f,
   input  logic        use_acc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] S,
   output logic        c_out,
   output logic        O,
   output logic [31:0] acc,
   output logic        ovf_sticky,
   input  logic        clr_flags,
   output logic [15:0] op_count
);

   localparam int unsigned DEPTH = 2;

   localparam logic [1:0] c_F_SUM  = 2'b00;
   localparam logic [1:0] c_F_SUB  = 2'b01;
   localparam logic [1:0] c_F_AINV = 2'b10;
   localparam logic [1:0] c_F_INC  = 2'b11;

   // FIFO storage: each entry is {S, c_out, O}
   logic [33:0] r_mem [0:DEPTH-1];
   logic [1:0]  r_count;
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [33:0] r_head;
   logic [31:0] r_acc;
   logic        r_sticky;
   logic [15:0] r_op_count;

   logic [31:0] w_aop;
   logic [31:0] w_x;
   logic [31:0] w_y;
   logic        w_cin;
   logic [32:0] w_sum;
   logic        w_res_o;
   logic [33:0] w_res;
   logic        w_push;
   logic        w_pop;
   logic [1:0]  w_count_nxt;
   logic        w_rd_nxt;
   logic [33:0] w_head_nxt;

   assign w_aop = use_acc ? r_acc : A;

   // Operand shaping for the four functions around a single adder
   always_comb begin
      w_x   = w_aop;
      w_y   = B;
      w_cin = 1'b0;
      case (f)
         c_F_SUM:  begin w_x = w_aop;  w_y = B;     w_cin = 1'b0; end
         c_F_SUB:  begin w_x = w_aop;  w_y = ~B;    w_cin = 1'b1; end
         c_F_AINV: begin w_x = ~w_aop; w_y = B;     w_cin = 1'b0; end
         c_F_INC:  begin w_x = w_aop;  w_y = 32'd0; w_cin = 1'b1; end
         default:  begin w_x = w_aop;  w_y = B;     w_cin = 1'b0; end
      endcase
   end

   assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_cin};
   assign w_res_o = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
   assign w_res   = {w_sum[31:0], w_sum[32], w_res_o};

   // in_ready looks only at the registered count, so a same-cycle pop
   // never makes room for a same-cycle push
   assign in_ready    = (r_count < 2'd2) && !rst;
   assign out_valid   = (r_count != 2'd0);
   assign w_push      = in_valid && in_ready;
   assign w_pop       = out_valid && out_ready;
   assign w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
   assign w_rd_nxt    = r_rd_ptr ^ w_pop;

   // Next head: the entry being written this cycle if it lands in the next
   // read slot (empty FIFO, or push+pop with one entry), else stored data
   assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_res : r_mem[w_rd_nxt];

   // FIFO pointers, occupancy and storage
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count  <= 2'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_mem[0] <= '0;
         r_mem[1] <= '0;
      end else begin
         r_count  <= w_count_nxt;
         r_rd_ptr <= w_rd_nxt;
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_res;
            r_wr_ptr        <= ~r_wr_ptr;
         end
      end
   end

   // Registered head; holds its last value once the FIFO drains
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
      end else if (w_count_nxt != 2'd0) begin
         r_head <= w_head_nxt;
      end
   end

   // Accumulator and accepted-request counter advance on every accept
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc      <= 32'd0;
         r_op_count <= 16'd0;
      end else if (w_push) begin
         r_acc      <= w_sum[31:0];
         r_op_count <= r_op_count + 16'd1;
      end
   end

   // Sticky overflow: a new overflow takes priority over a clear
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (w_push && w_res_o) begin
         r_sticky <= 1'b1;
      end else if (clr_flags) begin
         r_sticky <= 1'b0;
      end
   end

   assign S          = r_head[33:2];
   assign c_out      = r_head[1];
   assign O          = r_head[0];
   assign acc        = r_acc;
   assign ovf_sticky = r_sticky;
   assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_unit_a_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_unit_a_sequencer
// Purpose  : Scoreboard bench for unit_a_sequencer. Expected results come
//            from an independent arithmetic model and are queued on accept,
//            then compared as the DUT retires them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unit_a_sequencer;

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [1:0]  f;
   logic        use_acc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] S;
   logic        c_out;
   logic        O;
   logic [31:0] acc;
   logic        ovf_sticky;
   logic        clr_flags;
   logic [15:0] op_count;

   int n_checks = 0;
   int n_errors = 0;

   res_t        sb[$];
   logic [31:0] m_acc;
   logic        m_sticky;
   logic [15:0] m_cnt;

   unit_a_sequencer u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .A          (A),
      .B          (B),
      .f          (f),
      .use_acc    (use_acc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .S          (S),
      .c_out      (c_out),
      .O          (O),
      .acc        (acc),
      .ovf_sticky (ovf_sticky),
      .clr_flags  (clr_flags),
      .op_count   (op_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference arithmetic using signed range checks rather than bit tricks
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn);
      res_t        r;
      logic [32:0] u;
      logic [31:0] na;
      longint      v;
      na = ~a;
      case (fn)
         2'b00: begin
            u = {1'b0, a} + {1'b0, b};
            v = longint'($signed(a)) + longint'($signed(b));
            r.c = u[32];
         end
         2'b01: begin
            u = {1'b0, a} - {1'b0, b};
            v = longint'($signed(a)) - longint'($signed(b));
            r.c = (a >= b);
         end
         2'b10: begin
            u = {1'b0, na} + {1'b0, b};
            v = longint'($signed(na)) + longint'($signed(b));
            r.c = u[32];
         end
         default: begin
            u = {1'b0, a} + 33'd1;
            v = longint'($signed(a)) + 64'sd1;
            r.c = u[32];
         end
      endcase
      r.s = u[31:0];
      r.o = (v > 64'sd2147483647) || (v < -64'sd2147483648);
      return r;
   endfunction

   // Retire monitor: compare the head each time it is popped
   always @(negedge clk) begin
      res_t e;
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("head_S", S, e.s);
            chk("head_c_out", 32'(c_out), 32'(e.c));
            chk("head_O", 32'(O), 32'(e.o));
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] fn, input logic ua);
      res_t e;
      A = a; B = b; f = fn; use_acc = ua; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            e = model(ua ? m_acc : a, b, fn);
            sb.push_back(e);
            m_acc = e.s;
            m_cnt = m_cnt + 16'd1;
            if (clr_flags) m_sticky = 1'b0;
            if (e.o) m_sticky = 1'b1;
            @(posedge clk); #1;
            return;
         end
         if (clr_flags) m_sticky = 1'b0;
         @(posedge clk); #1;
      end
      chk("send_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (clr_flags) m_sticky = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_acc"}, acc, m_acc);
      chk({tag, "_op_count"}, 32'(op_count), 32'(m_cnt));
      chk({tag, "_sticky"}, 32'(ovf_sticky), 32'(m_sticky));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; f = 2'b00; use_acc = 1'b0;
      out_ready = 1'b1; clr_flags = 1'b0;
      m_acc = '0; m_sticky = 1'b0; m_cnt = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_S", S, 32'd0);
      chk("rst_c_out", 32'(c_out), 32'd0);
      chk("rst_O", 32'(O), 32'd0);
      chk_state("rst");
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Four functions, one at a time; result visible the cycle after accept
      send(32'd6, 32'd6, 2'b00, 1'b0); chk("lat_sum", 32'(out_valid), 32'd1); idle(1);
      send(32'd6, 32'd6, 2'b01, 1'b0); chk("lat_sub", 32'(out_valid), 32'd1); idle(1);
      send(32'd0, 32'd6, 2'b10, 1'b0); chk("lat_ainv", 32'(out_valid), 32'd1); idle(1);
      send(32'd0, 32'd6, 2'b11, 1'b0); chk("lat_inc", 32'(out_valid), 32'd1); idle(1);
      chk_state("func");

      // Overflow corners, back to back with the consumer draining
      send(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
      chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 2'b01, 1'b0);
      send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b0);
      send(32'h7FFF_FFFF, 32'h8000_0000, 2'b10, 1'b0);
      idle(2);
      chk_state("ovf");

      // Sticky clear, and set winning over a simultaneous clear
      clr_flags = 1'b1;
      idle(1);
      chk("clr_alone", 32'(ovf_sticky), 32'd0);
      send(32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0);
      chk("set_beats_clr", 32'(ovf_sticky), 32'd1);
      idle(1);
      chk("clr_next", 32'(ovf_sticky), 32'd0);
      clr_flags = 1'b0;
      chk_state("sticky");

      // Chaining through the accumulator with no bubbles
      send(32'd5, 32'd0, 2'b11, 1'b0);
      send(32'd0, 32'd0, 2'b11, 1'b1);
      send(32'd0, 32'd0, 2'b11, 1'b1);
      send(32'd0, 32'd0, 2'b11, 1'b1);
      in_valid = 1'b0;
      chk("chain_acc", acc, 32'd9);
      idle(2);
      chk_state("chain");

      // Backpressure: two accepts fill the FIFO, third waits for a pop
      out_ready = 1'b0;
      send(32'd0, 32'd0, 2'b11, 1'b0);
      send(32'd1, 32'd0, 2'b11, 1'b0);
      A = 32'd2; B = 32'd0; f = 2'b11; use_acc = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      chk("full_in_ready_a", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("full_in_ready_b", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("full_in_ready_c", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("after_pop_in_ready", 32'(in_ready), 32'd1);
      send(32'd2, 32'd0, 2'b11, 1'b0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      idle(3);
      chk("drained", 32'(out_valid), 32'd0);
      chk_state("bp");

      // Reset in the middle of queued work
      out_ready = 1'b0;
      send(32'd10, 32'd0, 2'b00, 1'b0);
      send(32'd20, 32'd0, 2'b00, 1'b0);
      in_valid = 1'b0;
      chk("pre_rst_acc", acc, 32'd20);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      m_acc = '0; m_cnt = '0; m_sticky = 1'b0;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready_after", 32'(in_ready), 32'd1);
      chk_state("mid_rst");

      // Clean operation after the reset
      out_ready = 1'b1;
      send(32'd3, 32'd4, 2'b00, 1'b0);
      idle(2);
      chk_state("final");
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
